// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the 8x16 register file
// with a pending-write scoreboard for RAW/WAW stall detection.
module rf_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              hazard,
  output logic              rf_enable,
  output logic [ADDR_W-1:0] rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [NUM_REGS-1:0] pending
);

  // rr_q=1 means the load unit wins the next conflict
  logic                rr_q, rr_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   reg_q, reg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic                alu_gnt, mem_gnt, xfer;
  logic [ADDR_W-1:0]   wb_reg;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_hits_issue;
  logic                issue_take;

  // Grant one requester; a reset edge drops any transfer
  always_comb begin
    alu_gnt = alu_valid & ~reset
            & (~mem_valid | ~rr_q);
    mem_gnt = mem_valid & ~reset
            & (~alu_valid | rr_q);
    xfer    = alu_gnt | mem_gnt;
    wb_reg  = alu_gnt ? alu_reg : mem_reg;
    wb_data = alu_gnt ? alu_data : mem_data;
    rr_d    = rr_q;
    if (alu_valid & mem_valid & ~reset)
      rr_d = alu_gnt;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  // Reservation blocks WAW unless the old producer retires this cycle
  always_comb begin
    wb_hits_issue = xfer & (wb_reg == issue_reg);
    issue_ready   = ~((issue_reg != '0)
                    & pend_q[issue_reg]
                    & ~wb_hits_issue);
    issue_take    = issue_valid & issue_ready
                  & (issue_reg != '0);
  end

  // Hazard looks at registered scoreboard only (no forwarding)
  always_comb begin
    hazard = ((chk_addr1 != '0) & pend_q[chk_addr1])
           | ((chk_addr2 != '0) & pend_q[chk_addr2]);
  end

  // Scoreboard next state: clear on retire, then set wins
  always_comb begin
    pend_d = pend_q;
    if (xfer)
      pend_d[wb_reg] = 1'b0;
    if (issue_take)
      pend_d[issue_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Write-port next state; r0 writes are swallowed
  always_comb begin
    en_d   = xfer & (wb_reg != '0);
    reg_d  = xfer ? wb_reg : reg_q;
    data_d = xfer ? wb_data : data_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= 1'b0;
      en_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
      pend_q <= '0;
    end else begin
      rr_q   <= rr_d;
      en_q   <= en_d;
      reg_q  <= reg_d;
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign rf_enable  = en_q;
  assign rf_wr_reg  = reg_q;
  assign rf_wr_data = data_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed + random stimulus, reference model feeding
// a write queue that a separate monitor drains against rf_enable pulses.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, alu_ready;
  logic [2:0]  alu_reg = '0;
  logic [15:0] alu_data = '0;
  logic        mem_valid = 1'b0, mem_ready;
  logic [2:0]  mem_reg = '0;
  logic [15:0] mem_data = '0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [2:0]  issue_reg = '0;
  logic [2:0]  chk_addr1 = '0, chk_addr2 = '0;
  logic        hazard, rf_enable;
  logic [2:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;
  logic [7:0]  pending;

  rf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg(mem_reg), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_reg(issue_reg),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard(hazard), .rf_enable(rf_enable),
    .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [2:0]  r;
    logic [15:0] d;
  } wr_t;

  wr_t q[$];
  wr_t mon_e;

  // reference state
  logic [7:0] pm = '0;
  bit pref_alu = 1'b1;
  bit last_ga = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rst,
                      input logic av, input logic [2:0] ar,
                      input logic [15:0] ad,
                      input logic mv, input logic [2:0] mr,
                      input logic [15:0] md,
                      input logic iv, input logic [2:0] ir,
                      input logic [2:0] c1, input logic [2:0] c2);
    bit ga, gm, xf, eir, eh;
    logic [2:0] wr;
    logic [15:0] wd;
    wr_t e;
    @(posedge clk);
    #1;
    reset = rst;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    issue_valid = iv; issue_reg = ir;
    chk_addr1 = c1; chk_addr2 = c2;
    #3;
    if (rst) begin
      pm = '0;
      pref_alu = 1'b1;
      last_ga = 1'b0;
    end else begin
      ga = av && (!mv || pref_alu);
      gm = mv && (!av || !pref_alu);
      xf = ga || gm;
      wr = ga ? ar : mr;
      wd = ga ? ad : md;
      eir = !(ir != 3'd0 && pm[ir] && !(xf && wr == ir));
      eh = (c1 != 3'd0 && pm[c1]) || (c2 != 3'd0 && pm[c2]);
      chk("alu_ready", 32'(alu_ready), 32'(ga));
      chk("mem_ready", 32'(mem_ready), 32'(gm));
      chk("issue_ready", 32'(issue_ready), 32'(eir));
      chk("hazard", 32'(hazard), 32'(eh));
      chk("pending", 32'(pending), 32'(pm));
      if (av && mv) pref_alu = gm;
      if (xf && wr != 3'd0) begin
        e.c = cyc; e.r = wr; e.d = wd;
        q.push_back(e);
      end
      if (xf) pm[wr] = 1'b0;
      if (iv && eir && ir != 3'd0) pm[ir] = 1'b1;
      last_ga = ga;
    end
  endtask

  task automatic idle(input logic [2:0] c1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  // monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].c < cyc - 1) begin
      total++;
      bad++;
      $display("FAIL missing_write: got none want r%0d=%0h",
               q[0].r, q[0].d);
      void'(q.pop_front());
    end
    if (rf_enable === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_write: got r%0d=%0h want none",
                 rf_wr_reg, rf_wr_data);
      end else begin
        mon_e = q.pop_front();
        chk("wr_latency", 32'(cyc - 1), 32'(mon_e.c));
        chk("rf_wr_reg", 32'(rf_wr_reg), 32'(mon_e.r));
        chk("rf_wr_data", 32'(rf_wr_data), 32'(mon_e.d));
      end
    end
  end

  logic        r_rst, r_av, r_mv, r_iv;
  logic [2:0]  r_ar, r_mr, r_ir, r_c1, r_c2;
  logic [15:0] r_ad, r_md;

  initial begin
    // reset held with a pending ALU request
    step(1, 1, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("post_reset_en", 32'(rf_enable), 32'd0);
    chk("post_reset_pend", 32'(pending), 32'd0);
    idle(0);

    // single ALU write
    step(0, 1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);

    // conflicts: ALU, MEM, ALU
    repeat (3)
      step(0, 1, 1, 16'h0001, 1, 2, 16'h0002, 0, 0, 0, 0);
    idle(0);
    idle(0);

    // scoreboard and hazard on r5
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    chk("pend_r5", 32'(pending), 32'h20);
    chk("waw_block", 32'(issue_ready), 32'd0);
    chk("raw_hazard", 32'(hazard), 32'd1);
    step(0, 0, 0, 0, 1, 5, 16'h5555, 0, 5, 5, 0);
    chk("no_forward", 32'(hazard), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0);
    chk("pend_clr", 32'(pending), 32'h00);
    chk("hazard_clr", 32'(hazard), 32'd0);
    chk("ready_clr", 32'(issue_ready), 32'd1);

    // same-edge set and clear of r4
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    step(0, 1, 4, 16'h4444, 0, 0, 0, 1, 4, 0, 0);
    chk("same_edge_rdy", 32'(issue_ready), 32'd1);
    idle(4);
    chk("same_edge_pend", 32'(pending), 32'h10);
    step(0, 0, 0, 0, 1, 4, 16'h4545, 0, 0, 0, 0);
    idle(0);

    // register 0 behaviour
    step(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    chk("r0_ready", 32'(mem_ready), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("r0_issue_rdy", 32'(issue_ready), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_pend", 32'(pending), 32'h00);
    chk("r0_hazard", 32'(hazard), 32'd0);

    // random traffic; held requests keep reg/data stable
    r_av = 0; r_mv = 0;
    r_ar = 0; r_mr = 0; r_ad = 0; r_md = 0;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      if (!(alu_valid && !last_ga && !reset)) begin
        r_av = 1'($urandom_range(0, 1));
        r_ar = 3'($urandom_range(0, 7));
        r_ad = 16'($urandom);
      end
      if (!(mem_valid && !mem_ready && !reset)) begin
        r_mv = 1'($urandom_range(0, 1));
        r_mr = 3'($urandom_range(0, 7));
        r_md = 16'($urandom);
      end
      r_iv = ($urandom_range(0, 2) == 0);
      r_ir = 3'($urandom_range(0, 7));
      r_c1 = 3'($urandom_range(0, 7));
      r_c2 = 3'($urandom_range(0, 7));
      step(r_rst, r_av, r_ar, r_ad, r_mv, r_mr, r_md,
           r_iv, r_ir, r_c1, r_c2);
    end

    repeat (3) idle(0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
